// File: rtl/sha_schedule_ctrl.sv
// sha_schedule_ctrl: SHA-256 message-schedule sequencer around a 1-cycle sha_extension.
// Optional stall counter enabled by defining SHA_SCHED_STALL_CNT_EN.
module sha_extension (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] w_16_i,
  input  logic [31:0] w_15_i,
  input  logic [31:0] w_7_i,
  input  logic [31:0] w_2_i,
  output logic [31:0] w_o
);
  logic [31:0] s0, s1;
  assign s0 = {w_15_i[6:0], w_15_i[31:7]} ^ {w_15_i[17:0], w_15_i[31:18]} ^ (w_15_i >> 3);
  assign s1 = {w_2_i[16:0], w_2_i[31:17]} ^ {w_2_i[18:0], w_2_i[31:19]} ^ (w_2_i >> 10);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_o <= '0;
    else w_o <= s1 + w_7_i + s0 + w_16_i;
endmodule

module sha_schedule_ctrl #(
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef SHA_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_e;
  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [3:0]  cnt_q;
  logic [5:0]  t_q;
  logic        done_q;
  logic [31:0] w, w_16, w_15, w_7, w_2;
  logic        in_xfer, fire, last, look;
  assign in_xfer = in_valid && in_ready;
  assign fire    = out_valid && out_ready;
  assign last    = t_q == 6'(NUM_WORDS - 1);
  // Lookahead only once the window shifts, so w holds W[t] whenever t >= 16
  assign look    = fire && t_q >= 6'd16;
  assign done    = done_q;
  always_comb begin
    state_d   = state_q;
    in_ready  = rst_n && state_q != STREAM;
    out_valid = state_q == STREAM;
    busy      = state_q != IDLE;
    out_idx   = out_valid ? t_q : '0;
    out_data  = !out_valid ? '0 : t_q < 6'd16 ? win_q[t_q[3:0]] : w;
    w_16      = look ? win_q[1]  : win_q[0];
    w_15      = look ? win_q[2]  : win_q[1];
    w_7       = look ? win_q[10] : win_q[9];
    w_2       = look ? win_q[15] : win_q[14];
    if (state_q == IDLE && in_xfer) state_d = LOAD;
    else if (state_q == LOAD && in_xfer && cnt_q == 4'd15) state_d = STREAM;
    else if (fire && last) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fire && last;
      if (in_xfer) begin
        win_q[cnt_q] <= in_data;
        cnt_q        <= cnt_q + 4'd1;
      end
      if (fire) t_q <= last ? '0 : t_q + 6'd1;
      if (look) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= w;
      end
    end
  sha_extension u_ext (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_16_i (w_16),
    .w_15_i (w_15),
    .w_7_i  (w_7),
    .w_2_i  (w_2),
    .w_o    (w)
  );
`ifdef SHA_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else if (state_q == IDLE && in_xfer) stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_sha_schedule_ctrl.sv
// tb_sha_schedule_ctrl: randomized bench against a plain SHA-256 schedule model.
module tb_sha_schedule_ctrl;
  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];
  logic        clk = 0, rst_n = 1;
  logic        in_valid = 0, out_ready = 0, in_ready, out_valid, busy, done;
  logic [31:0] in_data = 0, out_data;
  logic [5:0]  out_idx;
  logic        in_valid_b = 0, out_ready_b = 0, in_ready_b, out_valid_b, busy_b, done_b;
  logic [31:0] in_data_b = 0, out_data_b;
  logic [5:0]  out_idx_b;
  logic [31:0] got [64];
  int          n_chk = 0, n_fail = 0;
`ifdef SHA_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt_b;
`endif
  always #5 clk = ~clk;

  sha_schedule_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef SHA_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  sha_schedule_ctrl #(.NUM_WORDS(17)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_idx(out_idx_b), .out_ready(out_ready_b),
    .busy(busy_b), .done(done_b)
`ifdef SHA_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t expand(input blk_t b);
    sched_t w;
    for (int i = 0; i < 64; i++)
      if (i < 16) w[i] = b[i];
      else w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    return w;
  endfunction

  task automatic send(input blk_t b, input int pct);
    int i = 0, cyc = 0;
    while (i < 16 && cyc < 1000) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      check("busy_load", busy, i > 0);
      in_valid = $urandom_range(0, 99) < pct;
      in_data = in_valid ? b[i] : $urandom;
      if (in_valid && in_ready) i++;
      cyc++;
    end
    check("send_words", i, 16);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic recv(input sched_t exp, input int nw, input int stop_at, input int pct,
                      input int ha, input int hb, input bit poke, output int stalls, output int cycles);
    int k = 0, hc = 0;
    stalls = 0;
    cycles = 0;
    while (k < stop_at && cycles < 3000) begin
      @(negedge clk);
      out_ready = ((k == ha || k == hb) && hc < 20) ? 1'b0 : ($urandom_range(0, 99) < pct);
      in_valid = poke && $urandom_range(0, 1) == 1;
      in_data = $urandom;
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, k);
      check("out_data", out_data, exp[k]);
      check("in_ready_stream", in_ready, 0);
      check("done_early", done, 0);
      got[k] = out_data;
      if (out_ready) begin k++; hc = 0; end
      else begin stalls++; hc++; end
      cycles++;
    end
    check("recv_words", k, stop_at);
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    if (stop_at == nw) begin
      check("done_pulse", done, 1);
      check("out_valid_after", out_valid, 0);
      check("busy_after", busy, 0);
      check("in_ready_after", in_ready, 1);
`ifdef SHA_SCHED_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stalls);
`endif
    end
  endtask

  initial begin
    blk_t   abc, rb;
    sched_t e_abc;
    int     st, cyc, nb;
    logic [31:0] last_b;
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    e_abc = expand(abc);
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef SHA_SCHED_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    rst_n = 1;
    // back-to-back abc block, full throughput
    send(abc, 100);
    recv(e_abc, 64, 64, 100, -1, -1, 0, st, cyc);
    check("gapless", cyc, 64);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    check("abc_w18", got[18], 32'h7DA86405);
    check("abc_w63", got[63], 32'h12B1EDEB);
    @(negedge clk);
    check("done_once", done, 0);
    // random backpressure plus input pokes during STREAM
    send(abc, 70);
    recv(e_abc, 64, 64, 50, -1, -1, 1, st, cyc);
    // long stalls at t=16 and t=40
    send(abc, 100);
    recv(e_abc, 64, 64, 100, 16, 40, 0, st, cyc);
    check("hold_stalls", st, 40);
    // random blocks
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rb[i] = $urandom;
      send(rb, 60);
      recv(expand(rb), 64, 64, 60, -1, -1, 1, st, cyc);
    end
    // reset in the middle of STREAM
    send(abc, 100);
    recv(e_abc, 64, 30, 100, -1, -1, 0, st, cyc);
    check("pre_rst_idx", out_idx, 30);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    send(abc, 100);
    recv(e_abc, 64, 64, 100, -1, -1, 0, st, cyc);
    check("post_rst_w63", got[63], 32'h12B1EDEB);
    // NUM_WORDS = 17 instance
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("b_in_ready", in_ready_b, 1);
      in_valid_b = 1;
      in_data_b = abc[i];
    end
    @(negedge clk);
    in_valid_b = 0;
    out_ready_b = 1;
    nb = 0;
    cyc = 0;
    last_b = '0;
    while (!done_b && cyc < 100) begin
      if (out_valid_b) begin
        check("b_idx", out_idx_b, nb);
        check("b_data", out_data_b, e_abc[nb]);
        last_b = out_data_b;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    check("b_words", nb, 17);
    check("b_last", last_b, 32'h61626380);
    check("b_done", done_b, 1);
    check("b_out_valid_end", out_valid_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
